fft_sample_ram: RTL

FFT_SAMPLE_RAM -- requirements
Module: fft_sample_ram

---
 rtl/fft_sample_ram.sv | 110 +++++++++++
 1 files changed

// File: rtl/fft_sample_ram.sv
// Sample buffer for the FFT datapath: one write port, one read port with optional
// bit-reversed read addressing, and a self-clearing zero sweep after reset or on request.
module fft_sample_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_bitrev,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              clr_busy,
    output logic              access_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] eff_addr_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] mem [DEPTH];

    // Effective read address, optionally bit-reversed for FFT output ordering
    always_comb begin
        eff_addr_c = rd_addr;
        if (rd_bitrev) begin
            for (int unsigned i = 0; i < ADDR_W; i++) begin
                eff_addr_c[i] = rd_addr[ADDR_W-1-i];
            end
        end
    end

    // Single write port shared between the zero sweep and user writes
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_cnt;
                mem_wdata_c = '0;
            end else if (wr_en) begin
                mem_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Control FSM; the read samples mem before this edge's write lands (read-first)
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clr_busy   <= 1'b1;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            access_err <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_valid <= 1'b0;
                    if (wr_en || rd_req) begin
                        access_err <= 1'b1;
                    end
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state    <= RUN;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    rd_valid <= rd_req;
                    if (rd_req) begin
                        rd_data <= mem[eff_addr_c];
                    end
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule
